// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int BURST_DEFAULT = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo NREQ. Output is one-hot (all-zero when nothing requests).
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            any_o
);

    logic          found;
    logic [PW:0]   idx;

    assign any_o = |req_i;

    // Scan NREQ positions starting at ptr_i, keep only the first hit.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_i} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
            if (!found && req_i[idx[PW-1:0]]) begin
                gnt_o[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Bursting round-robin arbiter in front of an async-FIFO write port.
// One owner at a time moves up to BURST beats; a write is only accepted when
// the FIFO is guaranteed a free slot after the write already in flight.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DSIZE = 16,
    parameter int BURST = BURST_DEFAULT
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    input  logic                    awfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [NREQ-1:0]         grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e                 state_q, state_d;
    logic [NREQ-1:0]            grant_q, grant_d;
    logic [PW-1:0]              gidx_q, gidx_d;
    logic [PW-1:0]              rr_q, rr_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic                       winc_q;
    logic [DSIZE-1:0]           wdata_q;

    logic [NREQ-1:0][DSIZE-1:0] data_arr;
    logic [NREQ-1:0]            pick_oh;
    logic                       pick_any;
    logic [PW-1:0]              pick_idx;
    logic                       space_ok;
    logic                       g_valid;
    logic                       accept;
    logic                       last_beat;
    logic [PW-1:0]              rr_next;

    assign data_arr = req_data;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_q),
        .gnt_o (pick_oh),
        .any_o (pick_any)
    );

    // One-hot pick to binary index of the new owner.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) pick_idx = PW'(i);
        end
    end

    // A write already registered this cycle consumes the last free slot.
    assign space_ok  = !wfull && !(awfull && winc_q);
    assign g_valid   = req_valid[gidx_q];
    assign last_beat = (cnt_q == 8'(BURST - 1));
    assign rr_next   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

    // FSM outputs: handshake only toward the owner while a burst is open.
    always_comb begin
        accept    = (state_q == ST_BURST) && g_valid && space_ok && !wrst;
        req_ready = accept ? grant_q : '0;
    end

    // Next state: grant on any request, release on drop or full burst.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_BURST;
                    grant_d = pick_oh;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (!g_valid || (accept && last_beat)) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    rr_d    = rr_next;
                end else if (accept) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // Registered write port; data holds between writes.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            winc_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            winc_q <= accept;
            if (accept) wdata_q <= data_arr[gidx_q];
        end
    end

    assign winc  = winc_q;
    assign wdata = wdata_q;
    assign grant = grant_q;

endmodule
